adc_scan_sequencer: RTL and testbench
=====================================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 The block SHALL have parameters: NUM_CHANNELS, default 16, number of ADC inputs; CHANNEL_WIDTH, default $clog2(NUM_CHANNELS), channel index width; DATA_WIDTH, default 16, ADC word width; TIMEOUT_CYCLES, default 100000, maximum cycles to wait for a conversion.
REQ-002 The block SHALL have one clock, clk; reset rst_n is synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  scanning permitted
- sample_period  in  16  cycles between scan ticks
- adc_conversion_start  out  1  one-cycle convert strobe
- adc_channel  out  CHANNEL_WIDTH  channel being converted
- adc_conversion_done  in  1  conversion complete strobe
- adc_data  in  DATA_WIDTH  conversion result, valid with done
- fifo_full  in  1  downstream FIFO cannot accept a write
- sample_valid  out  1  sample produced this cycle
- sample_channel  out  CHANNEL_WIDTH  channel of produced sample
- sample_data  out  DATA_WIDTH  produced sample value
- sample_timestamp  out  32  free-running count captured at conversion start
- fifo_wr_en  out  1  write strobe to the FIFO
- scan_overrun  out  1  one-cycle pulse: tick lost during a scan
- drop_count  out  16  samples dropped because fifo_full
- timeout_count  out  16  conversions aborted by timeout
- busy  out  1  high in any state other than IDLE or WAIT_TICK

Function
REQ-004 A 32-bit free-running timestamp counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-005 A tick counter SHALL assert a tick every max(sample_period,1) cycles while enable=1; sample_period=0 SHALL behave as 1; while enable=0 the counter SHALL hold at 0.
REQ-006 FSM states SHALL be IDLE, WAIT_TICK, START, CONVERT, WRITE.
REQ-007 IDLE->WAIT_TICK when enable=1; WAIT_TICK->START on tick, selecting the first eligible channel from 0 upward.
REQ-008 START SHALL assert adc_conversion_start for exactly one cycle, drive adc_channel, capture the timestamp, and go to CONVERT.
REQ-009 adc_conversion_done SHALL be sampled only in CONVERT; a done pulse in any other state SHALL be ignored.
REQ-010 In CONVERT, done=1 SHALL capture adc_data and go to WRITE; if TIMEOUT_CYCLES cycles elapse without done, the conversion SHALL be abandoned, timeout_count incremented, and no sample produced.
REQ-011 In WRITE, sample_valid SHALL be high for one cycle with sample_channel, sample_data, sample_timestamp; fifo_wr_en = ~fifo_full in that cycle; if fifo_full=1, drop_count SHALL increment.
REQ-012 Sample latency SHALL be exactly 1 cycle from the done cycle to the sample_valid cycle.
REQ-013 After WRITE or timeout, the next eligible channel in ascending order SHALL be selected and the FSM SHALL go to START; when the index would pass NUM_CHANNELS-1 the scan ends and the FSM goes to WAIT_TICK (enable=1) or IDLE (enable=0).
REQ-014 A tick occurring while not in WAIT_TICK SHALL be discarded and scan_overrun pulsed for that cycle.
REQ-015 Deasserting enable mid-scan SHALL complete the current conversion and WRITE, then go to IDLE without further starts.
REQ-016 drop_count and timeout_count SHALL saturate at 0xFFFF.
REQ-017 sample_* outputs SHALL hold their last values when sample_valid=0.

Reset
REQ-018 With rst_n=0 at a clk edge, the FSM SHALL enter IDLE and all outputs, counters, and timestamps SHALL become 0, including a reset during CONVERT; a done pulse arriving after such a reset SHALL be ignored.

Configuration
REQ-019 If ADC_SEQ_CHMASK_EN is defined, an input port channel_mask [NUM_CHANNELS-1:0] SHALL exist; only channels whose bit is 1 are eligible. An all-zero mask SHALL keep the FSM in WAIT_TICK with no starts and no overrun pulses. Without the macro, the port SHALL be absent and all channels SHALL be eligible.

Verification
REQ-020 enable=1, period=2000, done 10 cycles after each start, fifo_full=0 -> 16 samples per tick, channels 0..15 in order, each sample_valid exactly 1 cycle after its done.
REQ-021 Channel 5 never returns done -> after 100000 cycles timeout_count=1, no sample for channel 5, channel 6 starts on the next cycle.
REQ-022 fifo_full=1 for the whole scan -> 16 sample_valid pulses, fifo_wr_en never high, drop_count=16.
REQ-023 period=100 with conversions taking 50 cycles each -> scan_overrun pulses, no start issued outside the START state.
REQ-024 rst_n=0 during CONVERT on channel 3 -> next cycle all outputs 0 and state IDLE; a late done produces no sample.
REQ-025 With ADC_SEQ_CHMASK_EN defined, mask=0x0011 -> only channels 0 and 4 converted per tick; with mask=0, zero starts over 10 ticks.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Periodic ADC scan sequencer: walks the eligible channels once per tick, emits one sample per
// conversion. Define ADC_SEQ_CHMASK_EN to add the channel_mask input.
module adc_scan_sequencer #(
  parameter int unsigned NUM_CHANNELS   = 16,
  parameter int unsigned CHANNEL_WIDTH  = $clog2(NUM_CHANNELS),
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [15:0]              sample_period,
`ifdef ADC_SEQ_CHMASK_EN
  input  logic [NUM_CHANNELS-1:0]  channel_mask,
`endif
  output logic                     adc_conversion_start,
  output logic [CHANNEL_WIDTH-1:0] adc_channel,
  input  logic                     adc_conversion_done,
  input  logic [DATA_WIDTH-1:0]    adc_data,
  input  logic                     fifo_full,
  output logic                     sample_valid,
  output logic [CHANNEL_WIDTH-1:0] sample_channel,
  output logic [DATA_WIDTH-1:0]    sample_data,
  output logic [31:0]              sample_timestamp,
  output logic                     fifo_wr_en,
  output logic                     scan_overrun,
  output logic [15:0]              drop_count,
  output logic [15:0]              timeout_count,
  output logic                     busy
);

  localparam int unsigned TimeoutWidth = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StWaitTick, StStart, StConvert, StWrite} state_e;

  state_e                   r_state, w_state_next, w_state_after;
  logic [31:0]              r_ts, r_start_ts, r_sample_ts;
  logic [15:0]              r_tick_cnt, r_drop_cnt, r_tmo_cnt;
  logic [TimeoutWidth-1:0]  r_to_cnt;
  logic [CHANNEL_WIDTH-1:0] r_chan, r_sample_channel;
  logic [DATA_WIDTH-1:0]    r_sample_data;

  logic [15:0]              w_period;
  logic                     w_tick, w_busy, w_timeout, w_conv_end;
  logic [NUM_CHANNELS-1:0]  w_mask;
  logic                     w_first_found, w_next_found;
  logic [CHANNEL_WIDTH-1:0] w_first_chan, w_next_chan;

`ifdef ADC_SEQ_CHMASK_EN
  assign w_mask = channel_mask;
`else
  assign w_mask = '1;
`endif

  assign w_period   = (sample_period == 16'd0) ? 16'd1 : sample_period;
  assign w_tick     = enable && (r_tick_cnt >= w_period - 16'd1);
  assign w_busy     = (r_state == StStart) || (r_state == StConvert) || (r_state == StWrite);
  assign w_timeout  = (r_state == StConvert) && !adc_conversion_done &&
                      (r_to_cnt == TimeoutWidth'(TIMEOUT_CYCLES - 1));
  assign w_conv_end = (r_state == StWrite) || w_timeout;

  // Downward sweep so the lowest eligible index wins.
  always_comb begin
    w_first_found = 1'b0;
    w_first_chan  = '0;
    w_next_found  = 1'b0;
    w_next_chan   = '0;
    for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
      if (w_mask[i]) begin
        w_first_found = 1'b1;
        w_first_chan  = CHANNEL_WIDTH'(i);
        if (i > int'(r_chan)) begin
          w_next_found = 1'b1;
          w_next_chan  = CHANNEL_WIDTH'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    if (!enable) begin
      w_state_after = StIdle;
    end else if (w_next_found) begin
      w_state_after = StStart;
    end else begin
      w_state_after = StWaitTick;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (enable) w_state_next = StWaitTick;
      StWaitTick: begin
        if (!enable) begin
          w_state_next = StIdle;
        end else if (w_tick && w_first_found) begin
          w_state_next = StStart;
        end
      end
      StStart:    w_state_next = StConvert;
      StConvert:  begin
        if (adc_conversion_done) begin
          w_state_next = StWrite;
        end else if (w_timeout) begin
          w_state_next = w_state_after;
        end
      end
      StWrite:    w_state_next = w_state_after;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    adc_conversion_start = (r_state == StStart);
    adc_channel          = r_chan;
    sample_valid         = (r_state == StWrite);
    sample_channel       = r_sample_channel;
    sample_data          = r_sample_data;
    sample_timestamp     = r_sample_ts;
    fifo_wr_en           = (r_state == StWrite) && !fifo_full;
    scan_overrun         = w_tick && w_busy;
    drop_count           = r_drop_cnt;
    timeout_count        = r_tmo_cnt;
    busy                 = w_busy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts             <= '0;
      r_tick_cnt       <= '0;
      r_chan           <= '0;
      r_to_cnt         <= '0;
      r_start_ts       <= '0;
      r_sample_channel <= '0;
      r_sample_data    <= '0;
      r_sample_ts      <= '0;
      r_drop_cnt       <= '0;
      r_tmo_cnt        <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (!enable || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 16'd1;
      end
      if (r_state == StWaitTick && w_tick && w_first_found) begin
        r_chan <= w_first_chan;
      end else if (w_conv_end && w_next_found && enable) begin
        r_chan <= w_next_chan;
      end
      if (r_state == StStart) begin
        r_to_cnt   <= '0;
        r_start_ts <= r_ts;
      end else if (r_state == StConvert) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (r_state == StConvert && adc_conversion_done) begin
        r_sample_channel <= r_chan;
        r_sample_data    <= adc_data;
        r_sample_ts      <= r_start_ts;
      end
      if (r_state == StWrite && fifo_full && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_timeout && r_tmo_cnt != 16'hFFFF) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: random periods, conversion delays and data; expected scan timing,
// samples and counters come from per-scan arithmetic on tick times and conversion durations.
module tb_adc_scan_sequencer;

  localparam int N  = 16;
  localparam int CW = 4;
  localparam int DW = 16;
  localparam int T  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   sample_period = 16'd300;
  logic          adc_conversion_done = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          fifo_full = 1'b0;
  logic [15:0]   mask_cur = 16'hFFFF;
  logic          adc_conversion_start, sample_valid, fifo_wr_en, scan_overrun, busy;
  logic [CW-1:0] adc_channel, sample_channel;
  logic [DW-1:0] sample_data;
  logic [31:0]   sample_timestamp;
  logic [15:0]   drop_count, timeout_count;

  adc_scan_sequencer #(
    .NUM_CHANNELS  (N),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .sample_period       (sample_period),
`ifdef ADC_SEQ_CHMASK_EN
    .channel_mask        (mask_cur),
`endif
    .adc_conversion_start(adc_conversion_start),
    .adc_channel         (adc_channel),
    .adc_conversion_done (adc_conversion_done),
    .adc_data            (adc_data),
    .fifo_full           (fifo_full),
    .sample_valid        (sample_valid),
    .sample_channel      (sample_channel),
    .sample_data         (sample_data),
    .sample_timestamp    (sample_timestamp),
    .fifo_wr_en          (fifo_wr_en),
    .scan_overrun        (scan_overrun),
    .drop_count          (drop_count),
    .timeout_count       (timeout_count),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_ovr = 0, n_start = 0, n_bad = 0, n_valid = 0, n_wr = 0;
  int checks = 0, passed = 0, fails = 0;
  int ts_base = 0, drop_exp = 0, tmo_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_overrun === 1'b1) n_ovr <= n_ovr + 1;
    if (adc_conversion_start === 1'b1) n_start <= n_start + 1;
    if (adc_conversion_start === 1'b1 && busy !== 1'b1) n_bad <= n_bad + 1;
    if (sample_valid === 1'b1) n_valid <= n_valid + 1;
    if (fifo_wr_en === 1'b1) n_wr <= n_wr + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_start(input int lim, output bit found);
    found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (adc_conversion_start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string where);
    chk({where, "_start"}, adc_conversion_start, 0);
    chk({where, "_adc_channel"}, adc_channel, 0);
    chk({where, "_valid"}, sample_valid, 0);
    chk({where, "_sample_channel"}, sample_channel, 0);
    chk({where, "_sample_data"}, sample_data, 0);
    chk({where, "_sample_ts"}, sample_timestamp, 0);
    chk({where, "_wr_en"}, fifo_wr_en, 0);
    chk({where, "_overrun"}, scan_overrun, 0);
    chk({where, "_drop"}, drop_count, 0);
    chk({where, "_timeout"}, timeout_count, 0);
    chk({where, "_busy"}, busy, 0);
  endtask

  // Disable, then re-enable with a new period; returns the cycle of the first accepted tick.
  task automatic restart(input int p, output int t);
    int peff;
    enable = 1'b0;
    @(negedge clk);
    sample_period = 16'(p);
    enable = 1'b1;
    peff = (p == 0) ? 1 : p;
    t = (peff == 1) ? cyc + 1 : cyc + peff - 1;
  endtask

  // One scan starting from the tick at cycle t. A conversion of length d occupies d+2 cycles
  // (start, d convert, write); a dead channel occupies T+1. Later ticks inside the scan are lost.
  task automatic run_scan(input int t, input int p, input int dead_ch, input bit full,
                          input int stop_ch, input int rst_ch, input int dmin, input int dmax,
                          output int next_t, output int ovr_exp);
    int exp_cyc, s, last_end, d, peff;
    bit found, have_last;
    logic [DW-1:0] last_data, dat;
    peff = (p == 0) ? 1 : p;
    exp_cyc = t + 1;
    last_end = t;
    have_last = 1'b0;
    last_data = '0;
    next_t = 0;
    ovr_exp = 0;
    fifo_full = full;
    for (int ch = 0; ch < N; ch++) begin
      if (!mask_cur[ch]) continue;
      wait_start(exp_cyc - cyc + 4, found);
      chk("start_seen", found, 1);
      if (!found) return;
      s = cyc;
      chk("start_cycle", s, exp_cyc);
      chk("start_channel", adc_channel, ch);
      chk("timeout_count", timeout_count, tmo_exp);
      if (have_last) chk("sample_hold", sample_data, last_data);
      if (ch == stop_ch) enable = 1'b0;
      if (ch == rst_ch) begin
        repeat (2) @(negedge clk);
        chk("busy_in_convert", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("reset_convert");
        rst_n = 1'b1;
        enable = 1'b0;
        ts_base = cyc;
        drop_exp = 0;
        tmo_exp = 0;
        adc_conversion_done = 1'b1;
        @(negedge clk);
        adc_conversion_done = 1'b0;
        chk("late_done_valid", sample_valid, 0);
        chk("late_done_busy", busy, 0);
        return;
      end
      if (ch == dead_ch) begin
        tmo_exp++;
        exp_cyc = s + T + 1;
        last_end = s + T;
        continue;
      end
      d = $urandom_range(dmax, dmin);
      repeat (d) @(negedge clk);
      dat = DW'($urandom);
      adc_data = dat;
      adc_conversion_done = 1'b1;
      @(negedge clk);
      adc_conversion_done = 1'b0;
      chk("sample_valid", sample_valid, 1);
      chk("sample_channel", sample_channel, ch);
      chk("sample_data", sample_data, dat);
      chk("sample_timestamp", sample_timestamp, 32'(s - ts_base));
      chk("fifo_wr_en", fifo_wr_en, !full);
      chk("drop_count", drop_count, drop_exp);
      if (full) drop_exp++;
      last_data = dat;
      have_last = 1'b1;
      last_end = cyc;
      exp_cyc = cyc + 1;
      if (ch == stop_ch) return;
    end
    ovr_exp = (last_end - t) / peff;
    next_t = t + ((last_end - t) / peff + 1) * peff;
  endtask

  initial begin
    int t, nt, ov, p, o0, v0, w0, s0, stop;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    ts_base = cyc;

    // Nominal scan; a done pulse while waiting for the tick must be ignored.
    p = $urandom_range(400, 300);
    restart(p, t);
    @(negedge clk);
    adc_conversion_done = 1'b1;
    @(negedge clk);
    adc_conversion_done = 1'b0;
    chk("stray_done_valid", sample_valid, 0);
    o0 = n_ovr; v0 = n_valid;
    run_scan(t, p, -1, 1'b0, -1, -1, 1, 12, nt, ov);
    @(negedge clk); #1;
    chk("nominal_overruns", n_ovr - o0, ov);
    chk("nominal_samples", n_valid - v0, 16);

    // FIFO full for the whole scan.
    o0 = n_ovr; v0 = n_valid; w0 = n_wr;
    run_scan(nt, p, -1, 1'b1, -1, -1, 1, 12, nt, ov);
    @(negedge clk); #1;
    fifo_full = 1'b0;
    chk("full_drop_total", drop_count, 16);
    chk("full_wr_en_count", n_wr - w0, 0);
    chk("full_samples", n_valid - v0, 16);
    chk("full_overruns", n_ovr - o0, ov);

    // Channel 5 never answers.
    o0 = n_ovr; v0 = n_valid;
    run_scan(nt, p, 5, 1'b0, -1, -1, 1, 12, nt, ov);
    @(negedge clk); #1;
    chk("timeout_total", timeout_count, 1);
    chk("timeout_samples", n_valid - v0, 15);
    chk("timeout_overruns", n_ovr - o0, ov);

    // Short period: ticks land mid-scan; two scans to confirm the next accepted tick.
    p = $urandom_range(30, 20);
    restart(p, t);
    for (int k = 0; k < 2; k++) begin
      o0 = n_ovr;
      run_scan(t, p, -1, 1'b0, -1, -1, 3, 10, t, ov);
      @(negedge clk); #1;
      chk("short_period_overruns", n_ovr - o0, ov);
    end

    // Period 0 behaves as 1: every busy cycle carries a lost tick.
    restart(0, t);
    for (int k = 0; k < 2; k++) begin
      o0 = n_ovr;
      run_scan(t, 0, -1, 1'b0, -1, -1, 1, 3, t, ov);
      @(negedge clk); #1;
      chk("period0_overruns", n_ovr - o0, ov);
    end

    // Enable dropped mid-scan: finish that channel, then idle with no further starts.
    stop = $urandom_range(10, 2);
    restart(300, t);
    run_scan(t, 300, -1, 1'b0, stop, -1, 1, 12, nt, ov);
    @(negedge clk); #1;
    chk("stop_busy", busy, 0);
    s0 = n_start;
    repeat (40) @(negedge clk);
    #1;
    chk("stop_no_starts", n_start - s0, 0);

    // Reset in the middle of converting channel 3.
    restart(300, t);
    run_scan(t, 300, -1, 1'b0, -1, 3, 4, 12, nt, ov);

`ifdef ADC_SEQ_CHMASK_EN
    mask_cur = 16'h0011;
    restart(300, t);
    v0 = n_valid;
    run_scan(t, 300, -1, 1'b0, -1, -1, 1, 12, nt, ov);
    @(negedge clk); #1;
    chk("mask_samples", n_valid - v0, 2);
    enable = 1'b0;
    @(negedge clk);
    mask_cur = 16'h0000;
    s0 = n_start; o0 = n_ovr;
    restart(10, t);
    repeat (105) @(negedge clk);
    #1;
    chk("zero_mask_starts", n_start - s0, 0);
    chk("zero_mask_overruns", n_ovr - o0, 0);
    chk("zero_mask_busy", busy, 0);
`endif

    #1;
    chk("start_only_when_busy", n_bad, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
